mult8_seq_ctrl: RTL and testbench

Sequencing controller that computes an 8×8 unsigned product by time-multiplexing one 4×4 unsigned multiplier over four partial-product steps.
- Operands are captured on a start handshake.
- Each partial product is shifted and accumulated.
- The 16-bit result is presented with a one-cycle done pulse.
- It sits between the tile I/O logic and the shared 4×4 multiplier datapath, so a wider multiply costs no extra multiplier area.

---
 rtl/mult8_seq_ctrl_pkg.sv | 16 +
 rtl/mult8_seq_ctrl_mul4x4.sv | 13 +
 rtl/mult8_seq_ctrl.sv | 102 ++++++++++
 tb/tb_mult8_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared widths, step-counter width and FSM state encoding for the
// sequential 8x8 multiplier controller.
package mult_pkg;

  localparam int OP_W    = 8;
  localparam int SLICE_W = 4;
  localparam int PROD_W  = 16;
  localparam int STEP_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult8_seq_ctrl_mul4x4.sv
// Combinational 4x4 unsigned multiplier slice shared by all four
// partial-product steps of the controller.
module mul4x4_u
  import mult_pkg::*;
(
  input  logic [SLICE_W-1:0]   i_a,
  input  logic [SLICE_W-1:0]   i_b,
  output logic [2*SLICE_W-1:0] o_p
);

  assign o_p = {{SLICE_W{1'b0}}, i_a} * {{SLICE_W{1'b0}}, i_b};

endmodule

// File: rtl/mult8_seq_ctrl.sv
// 8x8 unsigned multiply built from four passes through one 4x4 slice:
// accept operands, accumulate shifted partial products, pulse done.
module mult8_seq_ctrl
  import mult_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ena,
  input  logic              i_start,
  input  logic [OP_W-1:0]   i_op_a,
  input  logic [OP_W-1:0]   i_op_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [PROD_W-1:0] o_product
);

  state_t              r_state;
  state_t              w_nextState;
  logic [STEP_W-1:0]   r_step;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_b;
  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_product;
  logic [SLICE_W-1:0]  w_aNib;
  logic [SLICE_W-1:0]  w_bNib;
  logic [2*SLICE_W-1:0] w_pp;
  logic [PROD_W-1:0]   w_ppShifted;
  logic [PROD_W-1:0]   w_sum;

  // step[0] selects the high nibble of a (steps 1,3), step[1] that of b (steps 2,3)
  assign w_aNib = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_bNib = r_step[1] ? r_b[7:4] : r_b[3:0];

  mul4x4_u u_mul (
    .i_a (w_aNib),
    .i_b (w_bNib),
    .o_p (w_pp)
  );

  always_comb begin
    w_ppShifted = {8'h00, w_pp};
    case (r_step)
      2'd0:    w_ppShifted = {8'h00, w_pp};
      2'd1,
      2'd2:    w_ppShifted = {4'h0, w_pp, 4'h0};
      default: w_ppShifted = {w_pp, 8'h00};
    endcase
  end

  assign w_sum = r_acc + w_ppShifted;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else if (i_ena) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_nextState = ST_MUL;
      ST_MUL:  if (r_step == 2'd3) w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The final step writes product directly from the adder, so acc need not be re-read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else if (i_ena) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a    <= i_op_a;
            r_b    <= i_op_b;
            r_acc  <= '0;
            r_step <= '0;
          end
        end
        ST_MUL: begin
          r_acc  <= w_sum;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) r_product <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_DONE);
  assign o_product = r_product;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed-vector bench for mult8_seq_ctrl: latency, holding, ignored
// starts, ena stalls and asynchronous reset abort.
module tb_mult8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int nTotal = 0;
  int nBad   = 0;

  mult8_seq_ctrl dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ena     (ena),
    .i_start   (start),
    .i_op_a    (op_a),
    .i_op_b    (op_b),
    .o_busy    (busy),
    .o_done    (done),
    .o_product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    if (obs !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one start request and return just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 8'hxx;
    op_b  = 8'hxx;
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic waitDone(output int cnt);
    cnt = 0;
    while (!done && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int cnt;
    applyStimulus(a, b);
    waitDone(cnt);
    checkOutput("done_latency", cnt, 32'd4);
    checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
    checkOutput("product", {16'd0, product}, {16'd0, exp});
    @(posedge clk);
    #1;
    checkOutput("done_pulse_end", {31'd0, done}, 32'd0);
    checkOutput("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    int prevBusy;
    int nRise;
    int rise [3];
    int nDone;

    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    #12;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic 0x12 x 0x34");
    runOp(8'h12, 8'h34, 16'h03A8);

    $display("[TB] max operands then hold check");
    runOp(8'hFF, 8'hFF, 16'hFE01);
    applyStimulus(8'hA5, 8'h3C);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("hold_first_product", {16'd0, product}, 32'h0000FE01);
    end
    waitDone(cnt);
    checkOutput("second_latency", cnt, 32'd1);
    checkOutput("second_product", {16'd0, product}, 32'h000026AC);
    @(posedge clk);
    #1;

    $display("[TB] start held high");
    for (int i = 0; i < 3; i++) rise[i] = -1;
    nRise    = 0;
    prevBusy = 0;
    @(negedge clk);
    op_a  = 8'h00;
    op_b  = 8'h77;
    start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      if (busy && prevBusy == 0) begin
        if (nRise < 3) rise[nRise] = i;
        nRise++;
      end
      if (done) checkOutput("held_start_product", {16'd0, product}, 32'd0);
      prevBusy = busy ? 1 : 0;
    end
    start = 1'b0;
    checkOutput("held_start_accepts", nRise, 32'd3);
    checkOutput("held_start_first", rise[0], 32'd0);
    checkOutput("held_start_spacing1", rise[1] - rise[0], 32'd6);
    checkOutput("held_start_spacing2", rise[2] - rise[1], 32'd6);
    cnt = 0;
    while (busy && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("held_start_idle", {31'd0, busy}, 32'd0);

    $display("[TB] start and operand changes during MUL");
    applyStimulus(8'h10, 8'h10);
    @(posedge clk);
    #1;
    start = 1'b1;
    op_a  = 8'hFF;
    op_b  = 8'hFF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cnt);
    checkOutput("ignored_latency", cnt, 32'd1);
    checkOutput("ignored_product", {16'd0, product}, 32'h00000100);
    nDone = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) nDone++;
    end
    checkOutput("no_second_done", nDone, 32'd0);

    $display("[TB] ena stall during step 2");
    applyStimulus(8'h0F, 8'hF0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_busy", {31'd0, busy}, 32'd1);
    checkOutput("stall_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    ena = 1'b1;
    waitDone(cnt);
    checkOutput("stall_remaining", cnt, 32'd2);
    checkOutput("stall_product", {16'd0, product}, 32'h00000E10);
    @(negedge clk);
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_frozen", {31'd0, done}, 32'd1);
    checkOutput("done_frozen_product", {16'd0, product}, 32'h00000E10);
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("done_released", {31'd0, done}, 32'd0);

    $display("[TB] async reset during step 1");
    applyStimulus(8'hFF, 8'hFF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_product", {16'd0, product}, 32'd0);
    #1;
    rst_n = 1'b1;
    runOp(8'h03, 8'h05, 16'h000F);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
